fp8_mul_operand_sequencer: RTL and testbench

//  Upstream stage for the combinational 8-bit FP multiplier fp_mul_8bit (1 sign, 3 exp bias 3, 4 mantissa).

---
 rtl/fp8_mul_operand_sequencer_if.sv | 31 +++
 rtl/fp8_mul_operand_sequencer.sv | 126 ++++++++++++
 tb/tb_fp8_mul_operand_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp8_mul_operand_sequencer_if.sv
// Operand/product bus for the FP8 multiplier sequencer.
// master = producer/consumer side (also hosts the combinational multiplier),
// slave  = sequencer side.
interface fp8_mul_operand_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             pair_abort;
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic [7:0]       mul_result;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport master (
        output in_data, in_valid, pair_abort, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, out_data, out_valid, count, busy
    );

    modport slave (
        input  in_data, in_valid, pair_abort, mul_result, out_ready,
        output in_ready, mul_a, mul_b, out_data, out_valid, count, busy
    );
endinterface

// File: rtl/fp8_mul_operand_sequencer.sv
// Collects A/B operand bytes from one stream, queues complete pairs, presents
// the head pair to an external combinational FP8 multiplier and registers the
// product into a valid/ready output stage.
//
// state  | meaning
// LOAD_A | waiting for operand A byte
// LOAD_B | A held in a_hold, waiting for operand B byte
module fp8_mul_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input logic                        clk,
    input logic                        rst,
    fp8_mul_operand_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        LOAD_A = 1'b0,
        LOAD_B = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       a_hold;
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic             in_ready_c;
    logic             accept;
    logic             a_load;
    logic             push;
    logic             pop;
    logic [15:0]      head;

    // Input acceptance and pair-assembly next state; abort wins over any byte.
    always_comb begin
        in_ready_c = !rst && !bus.pair_abort && (count_q != FULL);
        accept     = bus.in_valid && in_ready_c;
        state_d    = state_q;
        a_load     = 1'b0;
        push       = 1'b0;
        if (bus.pair_abort) begin
            state_d = LOAD_A;
        end else if (accept) begin
            case (state_q)
                LOAD_A: begin
                    a_load  = 1'b1;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    push    = 1'b1;
                    state_d = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    // Pair FSM state and the held A operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_hold  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.pair_abort) begin
                a_hold <= '0;
            end else if (a_load) begin
                a_hold <= bus.in_data;
            end
        end
    end

    // Pair storage; contents are don't-care until counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {a_hold, bus.in_data};
        end
    end

    assign pop  = (count_q != '0) && (!out_valid_q || bus.out_ready);
    assign head = mem[rd_ptr];

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Output register: capture the product of the head pair when the stage is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_data_q  <= bus.mul_result;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mul_a     = (count_q != '0) ? head[15:8] : 8'h00;
    assign bus.mul_b     = (count_q != '0) ? head[7:0]  : 8'h00;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.busy      = (count_q != '0) || out_valid_q || (state_q == LOAD_B);
endmodule

// File: tb/tb_fp8_mul_operand_sequencer.sv
// Bench for fp8_mul_operand_sequencer with a behavioural FP8 multiplier in the loop.
module tb_fp8_mul_operand_sequencer;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [7:0] got_q[$];

    fp8_mul_operand_sequencer_if #(.DEPTH(DEPTH)) bus ();

    fp8_mul_operand_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FP8: 1 sign, 3 exponent (bias 3), 4 mantissa; exponent 0 treated as zero.
    function automatic logic [7:0] fp8_mul(input logic [7:0] a, input logic [7:0] b);
        logic s;
        int   ea, eb, e, p;
        s  = a[7] ^ b[7];
        ea = int'(a[6:4]);
        eb = int'(b[6:4]);
        if (ea == 0 || eb == 0) return {s, 7'h00};
        p = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        e = ea + eb - 3;
        if (p >= 512) begin
            p = p / 2;
            e = e + 1;
        end
        if (e >= 8) return {s, 7'h7F};
        if (e <= 0) return {s, 7'h00};
        return {s, 3'(e), 4'(p / 16)};
    endfunction

    assign bus.mul_result = fp8_mul(bus.mul_a, bus.mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every product handed downstream (values are pre-edge).
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at +1 after an edge; returns at +1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: byte %h never accepted, in_ready %b want 1", b, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_products(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (got_q.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL wait_timeout: products %0d want %0d", got_q.size(), n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h30; bus.pair_abort = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if ({bus.mul_a, bus.mul_b} !== 16'h0000) begin n_err++; $display("FAIL reset_mul: got %h%h want 0000", bus.mul_a, bus.mul_b); end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        #(-1 + 1);
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        got_q.delete();
        bus.out_ready = 1'b1;
        send_byte(8'h30);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_a: got %b want 1", bus.busy); end
        send_byte(8'h30);
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if ({bus.mul_a, bus.mul_b} !== 16'h3030) begin n_err++; $display("FAIL single_mul_drive: got %h%h want 3030", bus.mul_a, bus.mul_b); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h30) begin n_err++; $display("FAIL single_data: got %h want 30", bus.out_data); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL single_count_pop: got %0d want 0", bus.count); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_clear: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h30) begin n_err++; $display("FAIL single_data_hold: got %h want 30", bus.out_data); end
        n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL single_n_products: got %0d want 1", got_q.size()); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_v[4];
        logic [7:0] b_v[4];
        logic [7:0] e_v[4];
        a_v = '{8'h38, 8'h40, 8'hB0, 8'h00};
        b_v = '{8'h30, 8'h40, 8'h30, 8'h38};
        e_v = '{8'h38, 8'h50, 8'hB0, 8'h00};
        got_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(a_v[i]);
            send_byte(b_v[i]);
        end
        wait_products(4, 50);
        idle(3);
        n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL b2b_n_products: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== e_v[i]) begin n_err++; $display("FAIL b2b_product[%0d]: got %h want %h", i, got_q[i], e_v[i]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] e_v[5];
        logic [7:0] a, b;
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            e_v[i] = fp8_mul(a, b);
            send_byte(a);
            send_byte(b);
        end
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL stall_count_full: got %0d want 4", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== e_v[0]) begin n_err++; $display("FAIL stall_data: got %h want %h", bus.out_data, e_v[0]); end
        bus.in_data = 8'h30; bus.in_valid = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_full: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        idle(3);
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL stall_count_hold: got %0d want 4", bus.count); end
        n_cmp++; if (bus.out_data !== e_v[0]) begin n_err++; $display("FAIL stall_data_hold: got %h want %h", bus.out_data, e_v[0]); end
        bus.out_ready = 1'b1;
        wait_products(5, 60);
        idle(2);
        n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL stall_n_products: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== e_v[i]) begin n_err++; $display("FAIL stall_product[%0d]: got %h want %h", i, got_q[i], e_v[i]); end
        end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL stall_count_drained: got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_abort();
        got_q.delete();
        bus.out_ready = 1'b1;
        send_byte(8'h40);
        bus.pair_abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h38;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.pair_abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        send_byte(8'h38);
        send_byte(8'h30);
        wait_products(1, 20);
        idle(4);
        n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL abort_n_products: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 8'h38) begin n_err++; $display("FAIL abort_product: got %h want 38", got_q[0]); end
        end
    endtask

    task automatic test_reset_midstream();
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h38);
            send_byte(8'h40);
        end
        send_byte(8'h40);
        n_cmp++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_setup: count %0d valid %b want 3 1", bus.count, bus.out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        bus.out_ready = 1'b1;
        send_byte(8'h30);
        send_byte(8'h30);
        wait_products(1, 20);
        idle(4);
        n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL midrst_n_products: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== 8'h30) begin n_err++; $display("FAIL midrst_product: got %h want 30", got_q[0]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] a_model;
        logic       have_a;
        logic       acc;
        int         pairs;
        int         k;
        int         bad;
        exp_q.delete();
        got_q.delete();
        pairs = 0; k = 0; have_a = 1'b0; a_model = '0; bad = 0;
        while (pairs < 200 && k < 4000) begin
            bus.in_valid   = ($urandom_range(0, 99) < 70);
            bus.in_data    = 8'($urandom);
            bus.out_ready  = ($urandom_range(0, 99) < 50);
            bus.pair_abort = ($urandom_range(0, 99) < 3);
            #1;
            n_cmp++;
            if (int'(bus.count) > DEPTH ||
                int'(bus.count) + int'(bus.out_valid) + got_q.size() != pairs) begin
                n_err++; bad++;
                if (bad < 10)
                    $display("FAIL rand_occupancy: count %0d valid %b delivered %0d want pairs in flight %0d",
                             bus.count, bus.out_valid, got_q.size(), pairs - got_q.size());
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (bus.pair_abort) begin
                have_a = 1'b0;
            end else if (acc) begin
                if (!have_a) begin
                    a_model = bus.in_data;
                    have_a  = 1'b1;
                end else begin
                    exp_q.push_back(fp8_mul(a_model, bus.in_data));
                    have_a = 1'b0;
                    pairs++;
                end
            end
            #1;
            k++;
        end
        n_cmp++; if (pairs < 200) begin n_err++; $display("FAIL rand_budget: pairs %0d want 200", pairs); end
        bus.in_valid = 1'b0; bus.pair_abort = 1'b0; bus.out_ready = 1'b1;
        wait_products(exp_q.size(), 200);
        idle(3);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_n_products: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_product[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.pair_abort = 1'b0; bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_abort();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
